// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The cache takes the slave view; the fetch unit / controller pair takes the master view.
interface icache_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_addr;
  logic        icache_query_en;
  logic [31:0] head_addr;
  logic        icache_block_en;
  logic [31:0] icache_block_data;

  modport slave (
    input  fetch_req, fetch_addr, icache_block_en, icache_block_data,
    output inst_valid, inst_data, inst_addr, icache_query_en, head_addr
  );

  modport master (
    output fetch_req, fetch_addr, icache_block_en, icache_block_data,
    input  inst_valid, inst_data, inst_addr, icache_query_en, head_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Line contents survive flushes; only the in-flight request is dropped.
module icache #(
  parameter int INDEX_WIDTH = 6
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  input logic     flush_signal,
  icache_if.slave bus
);
  localparam int TAG_WIDTH = 16 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        query_en_q, query_en_d;
  logic [31:0] head_addr_q, head_addr_d;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [31:0]          data_q [LINES];

  logic [INDEX_WIDTH-1:0] fetch_idx, req_idx;
  logic [TAG_WIDTH-1:0]   fetch_tag, req_tag;
  logic                   hit;
  logic                   line_we;

  assign fetch_idx = bus.fetch_addr[INDEX_WIDTH+1:2];
  assign fetch_tag = bus.fetch_addr[17:INDEX_WIDTH+2];
  assign req_idx   = req_addr_q[INDEX_WIDTH+1:2];
  assign req_tag   = req_addr_q[17:INDEX_WIDTH+2];
  assign hit       = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = 1'b0;
    inst_data_d  = inst_data_q;
    inst_addr_d  = inst_addr_q;
    query_en_d   = query_en_q;
    head_addr_d  = head_addr_q;
    line_we      = 1'b0;

    if (flush_signal) begin
      // A fill arriving with the flush still carries correct data, so keep it.
      line_we    = (state_q == MISS) && bus.icache_block_en;
      query_en_d = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_req && !inst_valid_q) begin
            req_addr_d = bus.fetch_addr;
            if (hit) begin
              inst_valid_d = 1'b1;
              inst_data_d  = data_q[fetch_idx];
              inst_addr_d  = bus.fetch_addr;
            end else begin
              query_en_d  = 1'b1;
              head_addr_d = {bus.fetch_addr[31:2], 2'b00};
              state_d     = MISS;
            end
          end
        end
        MISS: begin
          // The controller ignores one cycle after block_en, so the query must drop on this edge.
          if (bus.icache_block_en) begin
            line_we      = 1'b1;
            inst_valid_d = 1'b1;
            inst_data_d  = bus.icache_block_data;
            inst_addr_d  = req_addr_q;
            query_en_d   = 1'b0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_addr_q  <= '0;
      query_en_q   <= 1'b0;
      head_addr_q  <= '0;
      valid_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_addr_q  <= inst_addr_d;
      query_en_q   <= query_en_d;
      head_addr_q  <= head_addr_d;
      if (line_we) valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && line_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= bus.icache_block_data;
    end
  end

  assign bus.inst_valid      = inst_valid_q;
  assign bus.inst_data       = inst_data_q;
  assign bus.inst_addr       = inst_addr_q;
  assign bus.icache_query_en = query_en_q;
  assign bus.head_addr       = head_addr_q;
endmodule
